// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : disp_pkg
// Purpose : Shared constants and types for the polyphonic key-display scanner
// Rev     : 1.0  initial release
// ============================================================================
package disp_pkg;

  localparam int NUM_SLOTS  = 16;   // voice slots on the packed display bus
  localparam int SLOT_W     = 16;   // bits per voice slot
  localparam int ON_BIT     = 9;    // note-on flag position inside a slot
  localparam int KEY_W      = 7;    // display key field, bits [6:0]
  localparam int NUM_KEYS   = 1 << KEY_W;
  localparam int KEY_OFFSET = 36;   // offset applied upstream when forming display keys

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/poly_disp_scan.sv
`default_nettype none
// ============================================================================
// Module  : poly_disp_scan
// Purpose : Snapshots the voice bus on frame_start, builds a key->voice map
//           one slot per cycle, then publishes it atomically for the renderer.
// Rev     : 1.0  initial release
// ============================================================================
module poly_disp_scan #(
  parameter int NUM_SLOTS = disp_pkg::NUM_SLOTS,
  parameter int ON_BIT    = disp_pkg::ON_BIT
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    frame_start,
  input  logic [NUM_SLOTS*disp_pkg::SLOT_W-1:0]   pd_in,
  input  logic [disp_pkg::KEY_W-1:0]              key_addr,
  output logic                                    key_lit,
  output logic [$clog2(NUM_SLOTS)-1:0]            key_voice,
  output logic [$clog2(NUM_SLOTS+1)-1:0]          active_count,
  output logic                                    busy,
  output logic                                    frame_done,
  output logic                                    overrun
);

  import disp_pkg::*;

  localparam int VOICE_W = $clog2(NUM_SLOTS);
  localparam int CNT_W   = $clog2(NUM_SLOTS + 1);

  state_t                         state_q;
  logic [NUM_SLOTS*SLOT_W-1:0]    snap_q;
  logic [VOICE_W-1:0]             slot_q;
  logic [NUM_KEYS-1:0]            build_map_q;
  logic [NUM_KEYS-1:0]            disp_map_q;
  logic [VOICE_W-1:0]             build_voice_q [NUM_KEYS];
  logic [VOICE_W-1:0]             disp_voice_q  [NUM_KEYS];
  logic [CNT_W-1:0]               build_cnt_q;
  logic [CNT_W-1:0]               disp_cnt_q;
  logic                           frame_done_q;
  logic                           overrun_q;
  logic                           key_lit_q;
  logic [VOICE_W-1:0]             key_voice_q;

  // Fields of the slot currently being scanned, taken from the frozen snapshot
  logic [KEY_W-1:0]               cur_key;
  logic                           cur_on;

  assign cur_key = snap_q[slot_q*SLOT_W +: KEY_W];
  assign cur_on  = snap_q[slot_q*SLOT_W + ON_BIT];

  // Frame FSM: capture, scan one slot per cycle, then copy build state to display
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      slot_q       <= '0;
      build_map_q  <= '0;
      disp_map_q   <= '0;
      build_cnt_q  <= '0;
      disp_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        build_voice_q[i] <= '0;
        disp_voice_q[i]  <= '0;
      end
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            snap_q      <= pd_in;
            build_map_q <= '0;
            build_cnt_q <= '0;
            slot_q      <= '0;
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          if (cur_on) begin
            build_cnt_q <= build_cnt_q + CNT_W'(1);
            // First (lowest) slot to claim a key keeps it
            if (!build_map_q[cur_key]) begin
              build_map_q[cur_key]   <= 1'b1;
              build_voice_q[cur_key] <= slot_q;
            end
          end
          if (slot_q == VOICE_W'(NUM_SLOTS - 1)) begin
            state_q <= COMMIT;
          end
          slot_q <= slot_q + VOICE_W'(1);
        end
        COMMIT: begin
          disp_map_q   <= build_map_q;
          disp_voice_q <= build_voice_q;
          disp_cnt_q   <= build_cnt_q;
          frame_done_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // A request that lands while a frame is in flight is dropped but remembered
      if (frame_start && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Registered read port against the published display copy only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_lit_q   <= 1'b0;
      key_voice_q <= '0;
    end else begin
      key_lit_q   <= disp_map_q[key_addr];
      key_voice_q <= disp_map_q[key_addr] ? disp_voice_q[key_addr] : '0;
    end
  end

  assign key_lit      = key_lit_q;
  assign key_voice    = key_voice_q;
  assign active_count = disp_cnt_q;
  assign busy         = (state_q != IDLE);
  assign frame_done   = frame_done_q;
  assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: doc/poly_disp_scan.md
POLY_DISP_SCAN -- requirements
Module: poly_disp_scan

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 16, meaning the number of 16-bit voice slots on the packed bus.
REQ-002 SHALL have parameter ON_BIT, default 9, meaning the bit position of note-on within a slot.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port frame_start, input, 1, a one-cycle pulse requesting a new snapshot (vblank start).
REQ-006 SHALL have port pd_in, input, 256, the packed display bus; slot k = pd_in[16k+15:16k], with bits [6:0] = display key and bit ON_BIT = note-on.
REQ-007 SHALL have port key_addr, input, 7, the renderer's key index to query.
REQ-008 SHALL have port key_lit, output, 1, the registered "key is sounding" flag for key_addr.
REQ-009 SHALL have port key_voice, output, 4, the registered slot number owning key_addr; 0 when unlit.
REQ-010 SHALL have port active_count, output, 5, the number of on-slots in the last committed frame (0..16).
REQ-011 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-012 SHALL have port frame_done, output, 1, a one-cycle pulse on commit.
REQ-013 SHALL have port overrun, output, 1, a sticky flag set when frame_start arrives while busy.

Function
REQ-014 SHALL implement the FSM states IDLE, SCAN and COMMIT.
REQ-015 IDLE + frame_start: SHALL capture pd_in into a snapshot register, clear the build map and build count, set slot counter to 0, and go to SCAN, all on the same edge.
REQ-016 SCAN: SHALL process one slot per cycle, slots 0..15 in order, over exactly 16 cycles, then go to COMMIT.
REQ-017 For each slot with ON_BIT set: SHALL increment the build count; if build_map[key] is clear, SHALL set it and record the slot number as the key's voice.
REQ-018 Duplicate keys: the lowest-numbered slot SHALL own the key; a later slot SHALL still increment the count.
REQ-019 Bits [15:10] and [8:7] of each slot SHALL be ignored.
REQ-020 Key value: SHALL take bits [6:0] as unsigned 0..127, with no range check; wrapped upstream values are displayed as-is.
REQ-021 COMMIT: SHALL copy build map, voice table and count to the display copies in one edge, pulse frame_done for the following cycle, and return to IDLE.
REQ-022 Latency: frame_start sampled at edge T implies scan edges T+1..T+16, commit at T+17, and frame_done high during cycle T+17..T+18; the next frame_start is accepted from edge T+18.
REQ-023 pd_in changes after the capture edge SHALL NOT affect the frame in progress.
REQ-024 frame_start while busy SHALL be ignored, and SHALL set overrun, which is cleared only by reset.
REQ-025 Read port: key_lit and key_voice SHALL reflect display[key_addr] one cycle after key_addr is presented, and SHALL never expose a partially built map.
REQ-026 A read in the commit cycle SHALL return the old map; the following cycle SHALL return the new map.

Reset
REQ-027 When reset_n is low, the block SHALL asynchronously force IDLE, clear snapshot, build and display maps, voice tables and counts, set key_lit=0, key_voice=0, active_count=0, busy=0, frame_done=0 and overrun=0.
REQ-028 Reset asserted mid-SCAN SHALL abandon the frame with no commit and no frame_done pulse.
REQ-029 After release, the first frame_start SHALL be honoured no earlier than the first clk edge with reset_n high.

Structure
REQ-030 A shared package disp_pkg SHALL hold NUM_SLOTS, SLOT_W=16, ON_BIT=9, KEY_W=7, the FSM state enum and the display-key offset constant 36 used upstream.
REQ-031 No sub-module: the block SHALL be a single module; the 128-entry maps SHALL be flop arrays, not RAM, because the commit is a whole-map copy.

Verification
REQ-032 The bench SHALL cover reset then idle: active_count=0; key_lit=0 for all 128 addresses; busy=0.
REQ-033 The bench SHALL cover slot0 = 0x0218 (on, key 24) and slot5 = 0x022B (on, key 43), others 0, then frame_start: frame_done 18 cycles later; key 24 gives lit/voice 0; key 43 gives lit/voice 5; active_count=2.
REQ-034 The bench SHALL cover slot3 = 0x0210, slot7 = 0x0210 and slot9 = 0x0010 (off): key 16 gives voice 3; active_count=2.
REQ-035 The bench SHALL cover a pd_in change at T+5 plus a second frame_start at T+8: the result matches the T snapshot; overrun=1; only one frame_done pulse.
REQ-036 The bench SHALL cover key_addr=24 polled every cycle across commit: it reads old value through commit cycle and new value from the next cycle.
REQ-037 The bench SHALL cover reset_n pulsed low at T+10: no frame_done; display stays cleared; the next frame completes normally.
